// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide engine owning the HI/LO register pair.
// Define MULDIV_DBZ_TRAP_EN to trap divide-by-zero at acceptance and expose dbz_err.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
`ifdef MULDIV_DBZ_TRAP_EN
    ,
    output logic             dbz_err
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [2:0] OP_MTHI = 3'b110;
    localparam logic [2:0] OP_MTLO = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               madd_q, madd_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
`ifdef MULDIV_DBZ_TRAP_EN
    logic               dbz_q, dbz_d;
`endif

    logic               signed_op, sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_s, fix_acc;
    logic [WIDTH-1:0]   quot, rem;

    // Signed ops iterate on magnitudes; signs are restored in FIX.
    assign signed_op = ~op[0];
    assign sa        = signed_op & operand_a[WIDTH-1];
    assign sb        = signed_op & operand_b[WIDTH-1];
    assign mag_a     = sa ? -operand_a : operand_a;
    assign mag_b     = sb ? -operand_b : operand_b;

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mcand_q};
    assign div_sub   = div_shift[WIDTH-1:0] - mcand_q;

    assign prod_s    = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    assign fix_acc   = prod_s + (madd_q ? {hi_q, lo_q} : {(2*WIDTH){1'b0}});
    // A zero divisor leaves the dividend magnitude as remainder; quotient is forced to all ones.
    assign quot      = dz_q ? {WIDTH{1'b1}} : (neg_q ? -acc_lo_q : acc_lo_q);
    assign rem       = rneg_q ? -acc_hi_q : acc_hi_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        madd_d   = madd_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULDIV_DBZ_TRAP_EN
        dbz_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (op == OP_MTHI) begin
                        hi_d   = operand_a;
                        done_d = 1'b1;
                    end else if (op == OP_MTLO) begin
                        lo_d   = operand_a;
                        done_d = 1'b1;
`ifdef MULDIV_DBZ_TRAP_EN
                    end else if (op[2] && operand_b == '0) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
`endif
                    end else begin
                        div_d    = op[2];
                        madd_d   = (op[2:1] == 2'b01);
                        neg_d    = sa ^ sb;
                        rneg_d   = sa;
                        dz_d     = op[2] && (operand_b == '0);
                        mcand_d  = op[2] ? mag_b : mag_a;
                        acc_hi_d = '0;
                        acc_lo_d = op[2] ? mag_a : mag_b;
                        cnt_d    = '0;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (div_q) begin
                        acc_hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!abort) begin
                    if (div_q) begin
                        hi_d = rem;
                        lo_d = quot;
                    end else begin
                        hi_d = fix_acc[2*WIDTH-1:WIDTH];
                        lo_d = fix_acc[WIDTH-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            madd_q   <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_DBZ_TRAP_EN
            dbz_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            madd_q   <= madd_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULDIV_DBZ_TRAP_EN
            dbz_q    <= dbz_d;
`endif
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;
`ifdef MULDIV_DBZ_TRAP_EN
    assign dbz_err = dbz_q;
`endif

endmodule
